// File: rtl/key_search_pkg.sv
// Shared constants and reference cipher for the key-search datapath.
// The function form is used by simulation models; the RTL cipher is in toy_cipher.
package key_search_pkg;

    localparam int unsigned DEF_WIDTH = 8;
    localparam int unsigned DEF_ROT   = 3;

    // rotl(key ^ plaintext, rot) at the default width, rotation taken modulo the width
    function automatic logic [DEF_WIDTH-1:0] rotl_cipher(
        input logic [DEF_WIDTH-1:0] key,
        input logic [DEF_WIDTH-1:0] plaintext,
        input int unsigned          rot
    );
        logic [DEF_WIDTH-1:0] x;
        x = key ^ plaintext;
        for (int unsigned i = 0; i < rot % DEF_WIDTH; i++) begin
            x = {x[DEF_WIDTH-2:0], x[DEF_WIDTH-1]};
        end
        return x;
    endfunction

endpackage

// File: rtl/key_search_datapath_toy_cipher.sv
// Combinational toy cipher: cipher = rotl(plaintext ^ key, ROT), WIDTH bits.
module toy_cipher #(
    parameter int unsigned WIDTH = 8,
    parameter int unsigned ROT   = 3
) (
    input  logic [WIDTH-1:0] key,
    input  logic [WIDTH-1:0] plaintext,
    output logic [WIDTH-1:0] cipher
);

    logic [WIDTH-1:0]   mixed;
    logic [2*WIDTH-1:0] doubled;

    // Rotate by shifting a doubled copy; the upper half is the rotated word, also for ROT = 0
    always_comb begin
        mixed   = plaintext ^ key;
        doubled = {mixed, mixed} << ROT;
        cipher  = doubled[2*WIDTH-1:WIDTH];
    end

endmodule

// File: rtl/key_search_datapath.sv
// Key-search datapath: candidate counter, cipher compare, winning-key latch,
// saturating attempt counter and sticky key-space exhaustion flag.
module key_search_datapath
    import key_search_pkg::*;
#(
    parameter int unsigned WIDTH = DEF_WIDTH,
    parameter int unsigned ROT   = DEF_ROT
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             clear,
    input  logic             UP,
    input  logic             en1,
    input  logic             en2,
    input  logic [WIDTH-1:0] plaintext,
    input  logic [WIDTH-1:0] target,
    output logic             found,
    output logic [WIDTH-1:0] key_cnt,
    output logic [WIDTH-1:0] key_out,
    output logic             key_valid,
    output logic [WIDTH:0]   tries,
    output logic             exhausted
);

    logic [WIDTH-1:0] cipher;

    toy_cipher #(
        .WIDTH(WIDTH),
        .ROT  (ROT)
    ) u_cipher (
        .key      (key_cnt),
        .plaintext(plaintext),
        .cipher   (cipher)
    );

    assign found = (cipher == target);

    always_ff @(posedge clk) begin
        if (reset) begin
            key_cnt   <= '1;
            key_out   <= '0;
            key_valid <= 1'b0;
            tries     <= '0;
            exhausted <= 1'b0;
        end else if (clear) begin
            key_cnt   <= '1;
            tries     <= '0;
            exhausted <= 1'b0;
            key_valid <= 1'b0;
        end else begin
            if (UP) begin
                key_cnt <= key_cnt + 1'b1;
            end
            // en1/en2 act on the pre-edge key_cnt even if UP is also high
            if (en1) begin
                if (tries != '1) begin
                    tries <= tries + 1'b1;
                end
                if ((key_cnt == '1) && !found) begin
                    exhausted <= 1'b1;
                end
            end
            if (en2) begin
                key_out   <= key_cnt;
                key_valid <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_key_search_datapath.sv
// Scoreboard bench for key_search_datapath: a reference model pushes expected
// outputs per driven cycle; they are popped and compared after the clock edge.
module tb_key_search_datapath;
    import key_search_pkg::*;

    localparam int unsigned W = 8;

    logic         clk = 1'b0;
    logic         reset, clear, up, en1, en2;
    logic [W-1:0] plaintext, target;
    logic         found, key_valid, exhausted;
    logic [W-1:0] key_cnt, key_out;
    logic [W:0]   tries;

    key_search_datapath #(
        .WIDTH(W),
        .ROT  (DEF_ROT)
    ) dut (
        .clk      (clk),
        .reset    (reset),
        .clear    (clear),
        .UP       (up),
        .en1      (en1),
        .en2      (en2),
        .plaintext(plaintext),
        .target   (target),
        .found    (found),
        .key_cnt  (key_cnt),
        .key_out  (key_out),
        .key_valid(key_valid),
        .tries    (tries),
        .exhausted(exhausted)
    );

    always #5 clk = ~clk;

    typedef enum int unsigned {SEL_KEY, SEL_TRIES, SEL_EXH, SEL_OUT, SEL_VALID, SEL_FOUND} sel_t;
    typedef struct {
        string       tag;
        sel_t        sel;
        logic [31:0] val;
    } exp_t;

    exp_t queue_exp[$];
    int   n_checks = 0;
    int   n_fail   = 0;

    logic [W-1:0] m_key, m_out;
    logic [W:0]   m_tries;
    logic         m_valid, m_exh;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] observe(input sel_t sel);
        case (sel)
            SEL_KEY:   return 32'(key_cnt);
            SEL_TRIES: return 32'(tries);
            SEL_EXH:   return 32'(exhausted);
            SEL_OUT:   return 32'(key_out);
            SEL_VALID: return 32'(key_valid);
            default:   return 32'(found);
        endcase
    endfunction

    task automatic push(input string tag, input sel_t sel, input logic [31:0] val);
        exp_t e;
        e.tag = tag;
        e.sel = sel;
        e.val = val;
        queue_exp.push_back(e);
    endtask

    task automatic drain();
        exp_t e;
        while (queue_exp.size() > 0) begin
            e = queue_exp.pop_front();
            check(e.tag, observe(e.sel), e.val);
        end
    endtask

    // Drive one cycle of control inputs, advance the model, compare after the edge
    task automatic step(input logic r, input logic c, input logic u, input logic e1, input logic e2);
        logic found_pre;
        @(negedge clk);
        reset = r; clear = c; up = u; en1 = e1; en2 = e2;
        found_pre = (rotl_cipher(m_key, plaintext, DEF_ROT) == target);
        if (r) begin
            m_key = '1; m_out = '0; m_valid = 1'b0; m_tries = '0; m_exh = 1'b0;
        end else if (c) begin
            m_key = '1; m_tries = '0; m_exh = 1'b0; m_valid = 1'b0;
        end else begin
            if (e1) begin
                if (m_tries != 9'd511) m_tries = m_tries + 1'b1;
                if (m_key == 8'hFF && !found_pre) m_exh = 1'b1;
            end
            if (e2) begin
                m_out = m_key; m_valid = 1'b1;
            end
            if (u) m_key = m_key + 1'b1;
        end
        push("sb_key_cnt", SEL_KEY, 32'(m_key));
        push("sb_tries", SEL_TRIES, 32'(m_tries));
        push("sb_exhausted", SEL_EXH, 32'(m_exh));
        push("sb_key_out", SEL_OUT, 32'(m_out));
        push("sb_key_valid", SEL_VALID, 32'(m_valid));
        push("sb_found", SEL_FOUND, 32'(rotl_cipher(m_key, plaintext, DEF_ROT) == target));
        @(posedge clk);
        #1;
        reset = 1'b0; clear = 1'b0; up = 1'b0; en1 = 1'b0; en2 = 1'b0;
        drain();
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    initial begin
        reset = 1'b1; clear = 1'b0; up = 1'b0; en1 = 1'b0; en2 = 1'b0;
        plaintext = 8'h5A; target = 8'h4A;
        m_key = '1; m_out = '0; m_valid = 1'b0; m_tries = '0; m_exh = 1'b0;

        // Reset state
        step(1, 0, 0, 0, 0);
        check("rst_key_cnt", 32'(key_cnt), 32'h0FF);
        check("rst_tries", 32'(tries), 32'h0);
        check("rst_key_valid", 32'(key_valid), 32'h0);

        // Basic match: key 0x13 hits on the 20th UP
        for (int i = 0; i < 20; i++) begin
            step(0, 0, 1, 0, 0);
            if (i == 18) check("no_early_found", 32'(found), 32'h0);
            step(0, 0, 0, 1, 0);
        end
        check("match_key_cnt", 32'(key_cnt), 32'h13);
        check("match_found", 32'(found), 32'h1);
        check("match_tries", 32'(tries), 32'd20);
        step(0, 0, 0, 0, 1);
        step(0, 0, 0, 0, 1);
        check("latch_key_out", 32'(key_out), 32'h13);
        check("latch_key_valid", 32'(key_valid), 32'h1);
        check("latch_key_hold", 32'(key_cnt), 32'h13);

        // Clear with UP in the same cycle: UP ignored, key_out kept
        step(0, 1, 1, 0, 0);
        check("clr_key_cnt", 32'(key_cnt), 32'h0FF);
        check("clr_tries", 32'(tries), 32'h0);
        check("clr_key_valid", 32'(key_valid), 32'h0);
        check("clr_key_out", 32'(key_out), 32'h13);
        step(0, 0, 1, 0, 0);
        check("clr_next_up", 32'(key_cnt), 32'h00);

        // Key zero
        plaintext = 8'h00; target = 8'h00;
        step(1, 0, 0, 0, 0);
        step(0, 0, 1, 0, 0);
        check("zero_key_cnt", 32'(key_cnt), 32'h00);
        check("zero_found", 32'(found), 32'h1);

        // Exhaustion over the full key space, match at 0x20 deliberately skipped
        target = 8'h01;
        step(1, 0, 0, 0, 0);
        for (int k = 0; k < 256; k++) begin
            step(0, 0, 1, 0, 0);
            if (k == 255) check("exh_before_last", 32'(exhausted), 32'h0);
            step(0, 0, 0, 1, 0);
        end
        check("exh_set", 32'(exhausted), 32'h1);
        check("exh_tries", 32'(tries), 32'd256);
        step(0, 0, 1, 0, 0);
        check("exh_wrap_key", 32'(key_cnt), 32'h00);
        check("exh_sticky", 32'(exhausted), 32'h1);

        // Tries saturation
        for (int n = 0; n < 600; n++) step(0, 0, 0, 1, 0);
        check("tries_sat", 32'(tries), 32'd511);

        // Match on key 0xFF must not flag exhaustion
        target = rotl_cipher(8'hFF, 8'h00, DEF_ROT);
        step(1, 0, 0, 0, 0);
        for (int k = 0; k < 256; k++) step(0, 0, 1, 0, 0);
        step(0, 0, 0, 1, 0);
        check("ff_match_no_exh", 32'(exhausted), 32'h0);

        // Reset wins over clear and all strobes
        step(0, 0, 0, 0, 1);
        step(1, 1, 1, 1, 1);
        check("rstp_key_cnt", 32'(key_cnt), 32'h0FF);
        check("rstp_key_out", 32'(key_out), 32'h00);
        check("rstp_key_valid", 32'(key_valid), 32'h0);
        check("rstp_tries", 32'(tries), 32'h0);
        check("rstp_exhausted", 32'(exhausted), 32'h0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
